// File: rtl/joy_db15_scan.sv
// DB15 joystick adapter scanner: drives the 165 chain strobes,
// shifts in 24 bits and publishes two glitch-filtered player words.
module joy_db15_scan #(
  parameter int CLK_DIV   = 12,
  parameter int FRAME_GAP = 1024,
  parameter bit FILTER    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        JOY_LOAD,
  output logic        JOY_CLK,
  input  logic        JOY_DATA,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int GW = $clog2(FRAME_GAP + 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_LO,
    S_HI,
    S_COMMIT,
    S_GAP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [TW-1:0]   tick_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [4:0]      k;
  logic [23:0]     shreg;
  logic [23:0]     prev;
  logic [1:0]      sync;
  logic            tick_end;
  logic            gap_end;
  logic            load_nx;
  logic            sclk_nx;
  logic            done_nx;
  logic            sample;

  assign tick_end = (tick_cnt == TW'(CLK_DIV - 1));
  assign gap_end  = (gap_cnt == GW'(FRAME_GAP - 1));
  assign sample   = sync[1];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_LOAD;
    else          state <= state_nx;
  end

  // Next-state: load (2 ticks), 24 lo/hi bit slots, commit, gap
  always_comb begin
    state_nx = state;
    unique case (state)
      S_LOAD:   if (tick_end && k == 5'd1) state_nx = S_LO;
      S_LO:     if (tick_end)
                  state_nx = (k == 5'd23) ? S_COMMIT : S_HI;
      S_HI:     if (tick_end) state_nx = S_LO;
      S_COMMIT: state_nx = S_GAP;
      S_GAP:    if (gap_end) state_nx = S_LOAD;
      default:  state_nx = S_LOAD;
    endcase
  end

  // Output decode from next state so strobes leave a flop
  always_comb begin
    load_nx = (state_nx != S_LOAD);
    sclk_nx = (state_nx == S_HI);
    done_nx = (state_nx == S_COMMIT);
  end

  // Registered strobes and frame pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      JOY_LOAD   <= 1'b1;
      JOY_CLK    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      JOY_LOAD   <= load_nx;
      JOY_CLK    <= sclk_nx;
      frame_done <= done_nx;
    end
  end

  // Serial data synchronizer, idles as released
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= 2'b11;
    else          sync <= {sync[0], JOY_DATA};
  end

  // Tick, bit index and gap counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      gap_cnt  <= '0;
      k        <= '0;
    end else begin
      if (state == S_LOAD || state == S_LO || state == S_HI)
        tick_cnt <= tick_end ? '0 : tick_cnt + 1'b1;
      else
        tick_cnt <= '0;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
      unique case (1'b1)
        (state == S_LOAD): if (tick_end)
                             k <= (k == 5'd0) ? 5'd1 : 5'd0;
        (state == S_HI):   if (tick_end) k <= k + 5'd1;
        (state == S_COMMIT): k <= '0;
        default: ;
      endcase
    end
  end

  // Shift capture and filtered commit of the player words
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '1;
      prev      <= '1;
      joystick1 <= '0;
      joystick2 <= '0;
    end else begin
      if (state == S_LO && tick_end) shreg[k] <= sample;
      if (state == S_COMMIT) begin
        if (!FILTER || shreg == prev) begin
          joystick1 <= {4'b0, ~shreg[11:0]};
          joystick2 <= {4'b0, ~shreg[23:12]};
        end
        prev <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_joy_db15_scan.sv
// Bench for joy_db15_scan with a behavioural 74HC165 chain
// per instance; directed steps with hand-computed cycle counts.
module tb_joy_db15_scan;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_a, sclk_a, data_a, done_a;
  logic        load_b, sclk_b, data_b, done_b;
  logic [15:0] j1_a, j2_a, j1_b, j2_b;
  logic [23:0] pins_a, pins_b;
  logic [23:0] ch_a = '1;
  logic [23:0] ch_b = '1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          t;
  int          fr;

  always #5 clk = ~clk;

  joy_db15_scan #(.CLK_DIV(4), .FRAME_GAP(16), .FILTER(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .JOY_LOAD(load_a), .JOY_CLK(sclk_a), .JOY_DATA(data_a),
    .joystick1(j1_a), .joystick2(j2_a), .frame_done(done_a)
  );

  joy_db15_scan #(.CLK_DIV(2), .FRAME_GAP(16), .FILTER(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .JOY_LOAD(load_b), .JOY_CLK(sclk_b), .JOY_DATA(data_b),
    .joystick1(j1_b), .joystick2(j2_b), .frame_done(done_b)
  );

  always @(posedge sclk_a or negedge load_a)
    if (!load_a) ch_a <= pins_a;
    else         ch_a <= {1'b1, ch_a[23:1]};

  always @(posedge sclk_b or negedge load_b)
    if (!load_b) ch_b <= pins_b;
    else         ch_b <= {1'b1, ch_b[23:1]};

  assign data_a = ch_a[0];
  assign data_b = ch_b[0];

  always @(posedge clk)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_done_a(output int at);
    at = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done_a) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    pins_a  = '1;
    pins_b  = '0;
    repeat (3) @(negedge clk);
    chk("rst_load", load_a, 1'b1);
    chk("rst_sclk", sclk_a, 1'b0);
    chk("rst_j1", j1_a, 16'h0);
    chk("rst_j2", j2_a, 16'h0);
    chk("rst_done", done_a, 1'b0);
    reset_n = 1'b1;

    wait_cyc(1);
    chk("load_low_c1", load_a, 1'b0);
    chk("sclk_low_c1", sclk_a, 1'b0);
    wait_cyc(7);
    chk("load_low_c7", load_a, 1'b0);
    wait_cyc(8);
    chk("load_high_c8", load_a, 1'b1);
    wait_cyc(11);
    chk("sclk_lo_c11", sclk_a, 1'b0);
    wait_cyc(12);
    chk("sclk_hi_c12", sclk_a, 1'b1);

    wait_cyc(98);
    chk("b_done_c98", done_b, 1'b1);
    chk("b_j1_pre", j1_b, 16'h0);
    wait_cyc(99);
    chk("b_j1_all", j1_b, 16'h0FFF);
    chk("b_j2_all", j2_b, 16'h0FFF);

    fr = 1;
    wait_done_a(t);
    chk("f1_done_cyc", t, 196);
    @(negedge clk);
    chk("f1_done_width", done_a, 1'b0);
    chk("f1_j1", j1_a, 16'h0);
    chk("f1_j2", j2_a, 16'h0);

    fr = 2;
    wait_done_a(t);
    chk("f2_done_cyc", t, 213 * fr - 17);
    @(negedge clk);
    pins_a = 24'hFFFFEF;

    fr = 3;
    wait_done_a(t);
    chk("f3_done_cyc", t, 213 * fr - 17);
    @(negedge clk);
    chk("f3_j1_held", j1_a, 16'h0);

    fr = 4;
    wait_done_a(t);
    chk("f4_done_cyc", t, 213 * fr - 17);
    @(negedge clk);
    chk("f4_j1_bit4", j1_a, 16'h0010);
    chk("f4_j2", j2_a, 16'h0);
    pins_a = 24'hFFE7FF;

    fr = 5;
    wait_done_a(t);
    chk("f5_done_cyc", t, 213 * fr - 17);
    @(negedge clk);
    chk("f5_j1_held", j1_a, 16'h0010);
    chk("f5_j2_held", j2_a, 16'h0);

    fr = 6;
    wait_done_a(t);
    chk("f6_done_cyc", t, 213 * fr - 17);
    @(negedge clk);
    chk("f6_j1", j1_a, 16'h0800);
    chk("f6_j2", j2_a, 16'h0001);
    pins_a = 24'hFF67FF;

    fr = 7;
    wait_done_a(t);
    chk("f7_done_cyc", t, 213 * fr - 17);
    @(negedge clk);
    chk("f7_j1_held", j1_a, 16'h0800);
    chk("f7_j2_held", j2_a, 16'h0001);
    pins_a = 24'hFFE7FF;

    fr = 8;
    wait_done_a(t);
    chk("f8_done_cyc", t, 213 * fr - 17);
    @(negedge clk);
    chk("f8_j2_held", j2_a, 16'h0001);

    fr = 9;
    wait_done_a(t);
    chk("f9_done_cyc", t, 213 * fr - 17);
    @(negedge clk);
    chk("f9_j1", j1_a, 16'h0800);
    chk("f9_j2", j2_a, 16'h0001);

    wait_cyc(213 * fr - 17 + 107);
    chk("mid_load_idle", load_a, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_load", load_a, 1'b1);
    chk("mid_rst_sclk", sclk_a, 1'b0);
    chk("mid_rst_j1", j1_a, 16'h0);
    chk("mid_rst_j2", j2_a, 16'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    wait_cyc(1);
    chk("r_load_low", load_a, 1'b0);
    wait_done_a(t);
    chk("r1_done_cyc", t, 196);
    @(negedge clk);
    chk("r1_j1_held", j1_a, 16'h0);
    chk("r1_j2_held", j2_a, 16'h0);
    wait_done_a(t);
    chk("r2_done_cyc", t, 409);
    @(negedge clk);
    chk("r2_j1", j1_a, 16'h0800);
    chk("r2_j2", j2_a, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
